// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

    // Loader phases: length header, payload, checksum, then a terminal state.
    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    // Number of little-endian length bytes that open every frame.
    localparam int LEN_BYTES = 4;

    // Width of the running payload checksum.
    localparam int CSUM_W = 8;

    // Byte enables for a word whose highest filled lane is last_lane.
    function automatic logic [3:0] lane_strb(input logic [1:0] last_lane);
        logic [3:0] strb;
        case (last_lane)
            2'd0:    strb = 4'b0001;
            2'd1:    strb = 4'b0011;
            2'd2:    strb = 4'b0111;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready handshake; the write port has none.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    // Host side: drives bytes, observes readiness and the write port.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  wr_strb
    );

    // Loader side: consumes bytes and drives the write port.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data,
        output wr_strb
    );
endinterface

// File: rtl/imem_byte_packer.sv
// Packs accepted payload bytes into little-endian 32-bit words with strobes.
// Latency: word presented combinationally on the push that completes it.
// Backpressure: none; the parent only pushes on an accepted payload byte.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  logic        last,
    input  logic [7:0]  lane_byte,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic [3:0]  word_strb
);

    // Bytes of the word under construction; lanes not yet filled stay zero.
    logic [31:0] lane_buf;
    logic [1:0]  lane;

    // Merge the incoming byte into its lane and decide whether the word is complete.
    always_comb begin
        word_data  = lane_buf | (32'(lane_byte) << {lane, 3'b000});
        word_strb  = lane_strb(lane);
        word_valid = push && ((lane == 2'd3) || last);
    end

    // Advance the lane on each push; an emitted word restarts from an empty buffer.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            lane_buf <= '0;
            lane     <= '0;
        end else if (push) begin
            if (word_valid) begin
                lane_buf <= '0;
                lane     <= '0;
            end else begin
                lane_buf <= word_data;
                lane     <= lane + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (len32 LE, payload, sum8) into instruction memory.
// Latency: one write per 4 payload bytes, registered on the accepting edge.
// Backpressure: in_ready high in LEN/DATA/CSUM, low once the frame is decided.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_BYTES = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_rst_n,
    output logic          done,
    output logic          err
);

    state_t              state;
    logic [31:0]         len;
    logic [1:0]          len_cnt;
    logic [31:0]         byte_cnt;
    logic [CSUM_W-1:0]   sum;

    logic                accept;
    logic [31:0]         len_full;
    logic                data_last;
    logic                rearm;
    logic                pack_push;
    logic                word_valid;
    logic [31:0]         word_data;
    logic [3:0]          word_strb;

    // Handshake decode and the frame-length view including the byte on the bus.
    always_comb begin
        accept    = bus.in_valid && bus.in_ready;
        len_full  = {bus.in_data, len[23:0]};
        data_last = ((byte_cnt + 32'd1) == len);
        rearm     = start && ((state == ST_DONE) || (state == ST_ERR));
        pack_push = accept && (state == ST_DATA);
    end

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (rearm),
        .push       (pack_push),
        .last       (data_last),
        .lane_byte  (bus.in_data),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_strb  (word_strb)
    );

    // Frame FSM with all handshake, write-port and status outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_LEN;
            len          <= '0;
            len_cnt      <= '0;
            byte_cnt     <= '0;
            sum          <= '0;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.wr_strb  <= '0;
            cpu_rst_n    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                ST_LEN: begin
                    // Ready rises here on the first cycle out of reset.
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        len[{len_cnt, 3'b000} +: 8] <= bus.in_data;
                        len_cnt <= len_cnt + 2'd1;
                        if (len_cnt == 2'(LEN_BYTES - 1)) begin
                            if (len_full > 32'(MAX_BYTES)) begin
                                state        <= ST_ERR;
                                err          <= 1'b1;
                                bus.in_ready <= 1'b0;
                            end else if (len_full == 32'd0) begin
                                state <= ST_CSUM;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 32'd1;
                        sum      <= sum + bus.in_data;
                        if (word_valid) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= BASE_ADDR + {byte_cnt[31:2], 2'b00};
                            bus.wr_data <= word_data;
                            bus.wr_strb <= word_strb;
                        end
                        if (data_last) begin
                            state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        bus.in_ready <= 1'b0;
                        if (bus.in_data == sum) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (start) begin
                        state        <= ST_LEN;
                        len          <= '0;
                        len_cnt      <= '0;
                        byte_cnt     <= '0;
                        sum          <= '0;
                        bus.in_ready <= 1'b1;
                        cpu_rst_n    <= 1'b0;
                        done         <= 1'b0;
                        err          <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_LEN;
                end
            endcase
        end
    end

endmodule
